seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed driver for an N-digit common-anode 7-segment display. It replaces per-digit combinational decoding with a single scanned decoder. It takes packed 4-bit digit values and per-digit decimal-point/blank flags, snapshots them once per frame, and drives the shared segment bus and the digit enables. It also provides hex glyphs, leading-zero suppression, anti-ghosting guard time and PWM brightness. It sits between the clock/counter logic and the board's segment/anode pins.

## Interface
- NUM_DIGITS, 4, digits scanned (1..8)
- REFRESH_DIV, 100000, clk cycles per digit slot (≥ GUARD+2)
- GUARD, 2, cycles at slot start with all anodes off (≥1)
- ACTIVE_LOW, 1, 1 = seg/dp/an lit when 0; 0 = lit when 1
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- digits_in  in  4*NUM_DIGITS  digit i value in bits [4i+3:4i]; digit 0 = rightmost
- dp_in  in  NUM_DIGITS  decimal point request per digit
- blank_in  in  NUM_DIGITS  force digit dark
- lz_en  in  1  enable leading-zero suppression
- bright  in  4  brightness, 0 = off, 15 = full on
- seg  out  7  segments {a,b,c,d,e,f,g}, seg[6]=a
- dp  out  1  decimal point
- an  out  NUM_DIGITS  digit enables, one-hot when lit
- frame_tick  out  1  one-cycle pulse on the snapshot cycle

## Operation
- Prescaler p counts 0..REFRESH_DIV-1 and wraps. Digit index k advances on p wrap, NUM_DIGITS-1 → 0.
- Snapshot: when p==0 and k==0, load digits_in/dp_in/blank_in/lz_en into shadow registers and pulse frame_tick. All decoding uses shadow values only, so there is no tearing mid-frame.
- Glyphs (logical, 1 = lit, order a..g):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
- Leading-zero suppression: when lz_en is set, digit i (i>0) is dark if shadow value i is 0 and all digits above i are 0. Digit 0 is never suppressed. dp_i still lights on a suppressed digit.
- Dark digit (blank or suppressed): all segments off; dp follows dp_in.
- PWM: 4-bit counter w increments every clk, free-running. Lit window is bright==15, or w<bright.
- an[k] is active when GUARD ≤ p and the lit window holds. At all other times every anode is inactive.
- Polarity: when ACTIVE_LOW=1, seg, dp and an are inverted at the output register.

## Timing
- Reset (sync): p=0, k=0, w=0, shadows=0, frame_tick=0. Output registers load seg=off, dp=off, an=all off (7'h7F/1/all-1s when ACTIVE_LOW=1).
- First cycle after reset is low: p==0, k==0, so the snapshot loads on that edge.
- All outputs are registered. Outputs at cycle t+1 reflect p, k, w and the shadow values at cycle t.
- seg/dp change only while an is all off (GUARD ≥ 1). There is never overlap between digits at a slot boundary.
- Frame period is NUM_DIGITS*REFRESH_DIV cycles. frame_tick has exactly that spacing.
- Input changes outside the snapshot cycle are invisible until the next frame.
- Reset mid-frame: all state returns to reset values on the same edge. The scan restarts at digit 0.
- bright changes take effect immediately, not at the snapshot.
- NUM_DIGITS=1: k stays 0; the snapshot occurs every REFRESH_DIV cycles.

## Structure
- Package seg7_pkg holds:
  - the 16-entry glyph constant array (logical polarity)
  - SEG_OFF, the all-off logical constant
  - function glyph(hex) returning 7 bits
- Sub-module seg7_glyph_rom is the combinational hex → segments lookup via seg7_pkg. It replaces the old single-digit decoder; the active-low inversion stays in the driver.
- The top level contains the prescaler, digit index, PWM counter, shadow registers, suppression mask logic and the output register stage.

## Test plan
Benches use REFRESH_DIV=8, GUARD=2 and NUM_DIGITS=4 unless noted.
- Reset, then digits_in=16'h1234, bright=15, lz_en=0:
  - frame_tick at cycle 1 after release
  - digit 0 slot: an=4'b1110 from p=2 onward, seg=7'b1001100 ("4", active-low)
  - each digit then follows in order, with a 32-cycle frame
- digits_in=16'h00A0, lz_en=1 → digits 3 and 2 dark (seg=7'h7F), digit 1 shows "A"=7'b0001000, digit 0 shows "0"=7'b0000001.
- digits_in changed from 16'h1111 to 16'h2222 mid-frame → remaining slots of the current frame still show "1". "2" appears only after the next frame_tick.
- bright=4 → in each slot, an is active on exactly the lit-window cycles with w<4. bright=0 → an stays all-1s permanently; seg/dp continue to toggle.
- dp_in=4'b0100 with blank_in=4'b0100 → during the digit 2 slot, seg=7'h7F and dp=0. No other digit lights dp.
- reset asserted for one cycle during the digit 2 slot → the next cycle shows an all-off, p=0, k=0. A new snapshot and frame_tick follow on release.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the scanned 7-segment driver: logical glyph table
// (1 = segment lit, bit 6 = a ... bit 0 = g) and the lookup helper.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'b000_0000;

  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'b111_1110,  // 0
    7'b011_0000,  // 1
    7'b110_1101,  // 2
    7'b111_1001,  // 3
    7'b011_0011,  // 4
    7'b101_1011,  // 5
    7'b101_1111,  // 6
    7'b111_0000,  // 7
    7'b111_1111,  // 8
    7'b111_1011,  // 9
    7'b111_0111,  // A
    7'b001_1111,  // b
    7'b100_1110,  // C
    7'b011_1101,  // d
    7'b100_1111,  // E
    7'b100_0111   // F
  };

  function automatic logic [6:0] glyph(input logic [3:0] hex);
    return GLYPH_TABLE[hex];
  endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational hex -> 7-segment lookup in logical polarity (1 = lit).
// Output polarity is applied by the driver's output register.
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Table lookup of the glyph for the current hex value.
  always_comb begin
    seg = glyph(hex);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver. Inputs are captured once per
// frame into shadow registers, one digit is decoded per slot, anodes are
// held off for a guard interval at each slot start and gated by PWM.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  input  logic [3:0]              bright,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_GUARD = PW'(GUARD);
  localparam logic [KW-1:0] K_LAST  = KW'(NUM_DIGITS - 1);
  localparam logic          INV     = (ACTIVE_LOW != 0);
  localparam logic [6:0]    SEG_INV = {7{INV}};
  localparam logic [NUM_DIGITS-1:0] AN_INV = {NUM_DIGITS{INV}};

  // Timebase
  logic [PW-1:0] p_r;
  logic [KW-1:0] k_r;
  logic [3:0]    w_r;
  logic          snap_s;

  // Frame shadows
  logic [4*NUM_DIGITS-1:0] digits_sh_r;
  logic [NUM_DIGITS-1:0]   dp_sh_r;
  logic [NUM_DIGITS-1:0]   blank_sh_r;
  logic                    lz_sh_r;

  // Decode path
  logic [NUM_DIGITS-1:0] sup_s;
  logic                  zeros_above_s;
  logic [3:0]            cur_val_s;
  logic [6:0]            glyph_s;
  logic                  dark_s;
  logic [6:0]            seg_log_s;
  logic                  dp_log_s;
  logic                  lit_s;
  logic [NUM_DIGITS-1:0] an_log_s;

  // Output registers
  logic [6:0]            seg_r;
  logic                  dp_r;
  logic [NUM_DIGITS-1:0] an_r;
  logic                  frame_tick_r;

  assign snap_s = (p_r == {PW{1'b0}}) && (k_r == {KW{1'b0}});

  // Prescaler, digit index and free-running PWM counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_r <= {PW{1'b0}};
      k_r <= {KW{1'b0}};
      w_r <= 4'd0;
    end else begin
      w_r <= w_r + 4'd1;
      if (p_r == P_LAST) begin
        p_r <= {PW{1'b0}};
        if (k_r == K_LAST) begin
          k_r <= {KW{1'b0}};
        end else begin
          k_r <= k_r + KW'(1'b1);
        end
      end else begin
        p_r <= p_r + PW'(1'b1);
      end
    end
  end

  // Capture display inputs once per frame so a frame never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      digits_sh_r <= {(4*NUM_DIGITS){1'b0}};
      dp_sh_r     <= {NUM_DIGITS{1'b0}};
      blank_sh_r  <= {NUM_DIGITS{1'b0}};
      lz_sh_r     <= 1'b0;
    end else if (snap_s) begin
      digits_sh_r <= digits_in;
      dp_sh_r     <= dp_in;
      blank_sh_r  <= blank_in;
      lz_sh_r     <= lz_en;
    end else begin
      digits_sh_r <= digits_sh_r;
      dp_sh_r     <= dp_sh_r;
      blank_sh_r  <= blank_sh_r;
      lz_sh_r     <= lz_sh_r;
    end
  end

  // Leading-zero mask: walk from the leftmost digit down; a digit is
  // suppressed while it and everything to its left is zero (never digit 0).
  always_comb begin
    zeros_above_s = 1'b1;
    sup_s         = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zeros_above_s = zeros_above_s & (digits_sh_r[4*i +: 4] == 4'd0);
      if ((i > 0) && lz_sh_r && zeros_above_s) begin
        sup_s[i] = 1'b1;
      end else begin
        sup_s[i] = 1'b0;
      end
    end
  end

  assign cur_val_s = digits_sh_r[{k_r, 2'b00} +: 4];

  seg7_glyph_rom u_glyph (
    .hex (cur_val_s),
    .seg (glyph_s)
  );

  // Select the current digit's segments, dp and the gated anode pattern.
  always_comb begin
    dark_s   = blank_sh_r[k_r] | sup_s[k_r];
    dp_log_s = dp_sh_r[k_r];
    lit_s    = (bright == 4'd15) || (w_r < bright);
    if (dark_s) begin
      seg_log_s = SEG_OFF;
    end else begin
      seg_log_s = glyph_s;
    end
    if ((p_r >= P_GUARD) && lit_s) begin
      an_log_s = NUM_DIGITS'(1'b1) << k_r;
    end else begin
      an_log_s = {NUM_DIGITS{1'b0}};
    end
  end

  // Output register stage; board polarity is applied here only.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_r        <= SEG_OFF ^ SEG_INV;
      dp_r         <= 1'b0 ^ INV;
      an_r         <= {NUM_DIGITS{1'b0}} ^ AN_INV;
      frame_tick_r <= 1'b0;
    end else begin
      seg_r        <= seg_log_s ^ SEG_INV;
      dp_r         <= dp_log_s ^ INV;
      an_r         <= an_log_s ^ AN_INV;
      frame_tick_r <= snap_s;
    end
  end

  assign seg        = seg_r;
  assign dp         = dp_r;
  assign an         = an_r;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 8-cycle slots, guard 2,
// active-low). The driver pushes the expected output word for every clock
// edge from a cycle-count based reference model; a monitor pops and compares.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int GD = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   digits_in = 16'h0000;
  logic [3:0]    dp_in = 4'h0;
  logic [3:0]    blank_in = 4'h0;
  logic          lz_en = 1'b0;
  logic [3:0]    bright = 4'hF;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame_tick;

  int total = 0;
  int bad = 0;

  // expected word: {seg[6:0], dp, an[3:0], frame_tick}
  logic [12:0] exp_q[$];

  // reference model state
  int          mc = 0;
  logic [15:0] sh_dig = 16'h0;
  logic [3:0]  sh_dp = 4'h0;
  logic [3:0]  sh_bl = 4'h0;
  logic        sh_lz = 1'b0;

  seg7_scan_driver #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD(GD), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .lz_en(lz_en), .bright(bright),
    .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      4'hF: return 7'b1000111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Predict the outputs that the coming clock edge will register.
  task automatic model_push();
    int p, k, w;
    logic [3:0] v;
    logic [6:0] lseg;
    logic [3:0] lan;
    logic ldp, ft, dark, zab;
    if (reset) begin
      mc = 0; sh_dig = 16'h0; sh_dp = 4'h0; sh_bl = 4'h0; sh_lz = 1'b0;
      exp_q.push_back({7'h7F, 1'b1, 4'hF, 1'b0});
    end else begin
      p = mc % RD;
      k = (mc / RD) % ND;
      w = mc % 16;
      v = sh_dig[4*k +: 4];
      zab = 1'b1;
      for (int j = k; j < ND; j++) if (sh_dig[4*j +: 4] != 4'h0) zab = 1'b0;
      dark = sh_bl[k] || (sh_lz && (k > 0) && zab);
      lseg = dark ? 7'b0000000 : ref_glyph(v);
      ldp  = sh_dp[k];
      lan  = ((p >= GD) && ((bright == 4'hF) || (w < int'(bright)))) ? (4'b0001 << k) : 4'b0000;
      ft   = (p == 0) && (k == 0);
      exp_q.push_back({~lseg, ~ldp, ~lan, ft});
      if (ft) begin
        sh_dig = digits_in; sh_dp = dp_in; sh_bl = blank_in; sh_lz = lz_en;
      end
      mc++;
    end
  endtask

  // One clock: record expectation for the next edge, then advance to negedge.
  task automatic cyc();
    model_push();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic to_frame_start();
    while ((mc % (RD*ND)) != 0) cyc();
  endtask

  task automatic chk(input string name, input logic [12:0] got, input logic [12:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Scoreboard monitor: one pop per clock edge once predictions exist.
  initial begin
    logic [12:0] e, g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {seg, dp, an, frame_tick};
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL scan@%0t: got seg=%b dp=%b an=%b ft=%b want seg=%b dp=%b an=%b ft=%b",
                   $time, g[12:6], g[5], g[4:1], g[0], e[12:6], e[5], e[4:1], e[0]);
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    run(3);
    chk("reset_state", {seg, dp, an, frame_tick}, {7'h7F, 1'b1, 4'hF, 1'b0});

    // basic scan of 1234 at full brightness
    digits_in = 16'h1234; bright = 4'hF; lz_en = 1'b0;
    reset = 1'b0;
    cyc();
    chk("first_tick", {12'h0, frame_tick}, 13'd1);
    run(2);
    chk("d0_an", {9'h0, an}, 13'b1110);
    chk("d0_seg", {6'h0, seg}, 13'b1001100);
    run(96);

    // leading-zero suppression on 00A0
    to_frame_start();
    digits_in = 16'h00A0; lz_en = 1'b1;
    run(11);
    chk("lz_d1_seg", {6'h0, seg}, 13'b0001000);
    chk("lz_d1_an", {9'h0, an}, 13'b1101);
    run(16);
    chk("lz_d3_seg", {6'h0, seg}, 13'h7F);
    run(37);

    // mid-frame input change is invisible until the next snapshot
    lz_en = 1'b0;
    to_frame_start();
    digits_in = 16'h1111;
    run(32);
    run(12);
    digits_in = 16'h2222;
    run(15);
    chk("tear_d3_seg", {6'h0, seg}, 13'b1001111);
    run(8);
    chk("tear_d0_seg", {6'h0, seg}, 13'b0010010);
    run(40);

    // brightness
    bright = 4'd4; run(64);
    bright = 4'd0; run(64);
    chk("dark_an", {9'h0, an}, 13'hF);
    bright = 4'hF;

    // blank with decimal point on digit 2
    to_frame_start();
    digits_in = 16'h5678; dp_in = 4'b0100; blank_in = 4'b0100;
    run(19);
    chk("blank_d2", {seg, dp, an}, {7'h7F, 1'b0, 4'b1011});
    run(45);

    // reset during the digit 2 slot
    dp_in = 4'h0; blank_in = 4'h0;
    to_frame_start();
    run(19);
    reset = 1'b1;
    cyc();
    chk("midreset", {seg, dp, an, frame_tick}, {7'h7F, 1'b1, 4'hF, 1'b0});
    reset = 1'b0;
    cyc();
    chk("midreset_tick", {12'h0, frame_tick}, 13'd1);
    run(40);

    // randomized traffic
    for (int it = 0; it < 250; it++) begin
      for (int d = 0; d < ND; d++)
        digits_in[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      dp_in    = 4'($urandom_range(0, 15));
      blank_in = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      lz_en    = 1'($urandom_range(0, 1));
      bright   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) begin
        reset = 1'b1;
        run($urandom_range(1, 2));
        reset = 1'b0;
      end
      run($urandom_range(1, 40));
    end

    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
